// File: rtl/muldiv_pkg.sv
// Shared definitions for the MUL/DIV sequencer.
// - FC_MUL / FC_DIV: ALU function codes, identical to the values control decodes.
// - state_t: sequencer FSM states.
package muldiv_pkg;

    localparam int FC_WIDTH = 4;

    localparam logic [FC_WIDTH-1:0] FC_MUL = 4'b0001;
    localparam logic [FC_WIDTH-1:0] FC_DIV = 4'b0010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_iter_datapath.sv
// Iterative datapath shared by unsigned shift-add multiply and restoring divide.
// One iteration per cycle while step is high; load seeds the registers.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load                seed registers from a/b, latch mode_div
//   step                perform one iteration
//   mode_div            0 = multiply, 1 = divide (sampled with load)
//   a, b                multiplicand/dividend, multiplier/divisor
//   res_lo_nxt          value lo register takes after this step (product low / quotient)
//   res_hi_nxt          value hi register takes after this step (product high / remainder)
module muldiv_iter_datapath #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic         mode_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res_lo_nxt,
    output logic [W-1:0] res_hi_nxt
);

    // hi_q: product high half / partial remainder
    // lo_q: multiplier being shifted out / dividend shifting out, quotient shifting in
    logic [W-1:0] hi_q, lo_q, opd_q;
    logic         mode_q;

    logic [W:0]   mul_sum;
    logic [W:0]   shifted;
    logic [W-1:0] diff;
    logic         ge;
    logic [W-1:0] hi_nxt, lo_nxt;

    always_comb begin
        // Multiply: conditionally add multiplicand into high half, then shift the
        // whole {carry, hi, lo} right by one. Low bits of the product fill lo_q.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(W+1){1'b0}});

        // Divide: shift next dividend bit into the partial remainder and try the
        // subtraction. The remainder stays below the divisor, so the shifted value
        // needs one extra bit but the restored/subtracted result fits in W bits.
        shifted = {hi_q, lo_q[W-1]};
        ge      = (shifted >= {1'b0, opd_q});
        diff    = shifted[W-1:0] - opd_q;

        if (mode_q) begin
            hi_nxt = ge ? diff : shifted[W-1:0];
            lo_nxt = {lo_q[W-2:0], ge};
        end else begin
            hi_nxt = mul_sum[W:1];
            lo_nxt = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opd_q  <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            hi_q   <= '0;
            lo_q   <= mode_div ? a : b;
            opd_q  <= mode_div ? b : a;
            mode_q <= mode_div;
        end else if (step) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
        end
    end

    assign res_lo_nxt = lo_nxt;
    assign res_hi_nxt = hi_nxt;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV unit beside the execute-stage ALU. Holds the pipeline via
// stall while iterating, then presents a 2-word result for one DONE cycle.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start, func_code         request and op select, sampled only in IDLE
//   operand_a, operand_b     multiplicand/dividend, multiplier/divisor
//   flush                    abort anything in flight (priority over all)
//   busy                     high in MUL_RUN, DIV_RUN, DONE
//   stall                    pipeline hold (combinational from start in IDLE)
//   done                     one-cycle result-valid pulse
//   result_lo / result_hi    product low/high, or quotient/remainder
//   div_by_zero              one-cycle pulse after a DIV with operand_b == 0
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH          = 16,
    parameter int FUNCTION_CODE_WIDTH = 4,
    parameter logic [FUNCTION_CODE_WIDTH-1:0] MUL = muldiv_pkg::FC_MUL,
    parameter logic [FUNCTION_CODE_WIDTH-1:0] DIV = muldiv_pkg::FC_DIV
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [FUNCTION_CODE_WIDTH-1:0] func_code,
    input  logic [DATA_WIDTH-1:0]          operand_a,
    input  logic [DATA_WIDTH-1:0]          operand_b,
    input  logic                           flush,
    output logic                           busy,
    output logic                           stall,
    output logic                           done,
    output logic [DATA_WIDTH-1:0]          result_lo,
    output logic [DATA_WIDTH-1:0]          result_hi,
    output logic                           div_by_zero
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 accept_mul, accept_div, dz_req;
    logic                 running, last_iter;
    logic                 dbz_q;
    logic [DATA_WIDTH-1:0] dp_lo_nxt, dp_hi_nxt;

    assign accept_mul = (state_q == IDLE) && start && (func_code == MUL);
    assign accept_div = (state_q == IDLE) && start && (func_code == DIV) && (operand_b != '0);
    assign dz_req     = (state_q == IDLE) && start && (func_code == DIV) && (operand_b == '0);
    assign running    = (state_q == MUL_RUN) || (state_q == DIV_RUN);
    assign last_iter  = running && (cnt_q == CNT_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_mul)      state_d = MUL_RUN;
                    else if (accept_div) state_d = DIV_RUN;
                end
                MUL_RUN, DIV_RUN: begin
                    if (cnt_q == CNT_WIDTH'(1)) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result_lo <= '0;
            result_hi <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            dbz_q   <= !flush && dz_req;
            if (flush)
                cnt_q <= '0;
            else if (accept_mul || accept_div)
                cnt_q <= CNT_WIDTH'(DATA_WIDTH);
            else if (running)
                cnt_q <= cnt_q - CNT_WIDTH'(1);
            // Results capture the final iteration's outcome on the edge into DONE
            // so they are already valid while done is high.
            if (!flush && last_iter) begin
                result_lo <= dp_lo_nxt;
                result_hi <= dp_hi_nxt;
            end
        end
    end

    muldiv_iter_datapath #(.W(DATA_WIDTH)) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (!flush && (accept_mul || accept_div)),
        .step       (!flush && running),
        .mode_div   (accept_div),
        .a          (operand_a),
        .b          (operand_b),
        .res_lo_nxt (dp_lo_nxt),
        .res_hi_nxt (dp_hi_nxt)
    );

    // Stall must rise in the issuing cycle, hence the combinational accept term.
    assign stall       = accept_mul || accept_div || running;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  func_code;
    logic [15:0] operand_a, operand_b;
    logic        flush;
    logic        busy, stall, done, div_by_zero;
    logic [15:0] result_lo, result_hi;

    int tests = 0;
    int fails = 0;

    localparam logic [3:0] F_MUL = 4'b0001;
    localparam logic [3:0] F_DIV = 4'b0010;
    localparam logic [3:0] F_ADD = 4'b1111;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .func_code   (func_code),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one accepted op and follow it to its done cycle (returns at the
    // negedge inside the DONE cycle).
    task automatic run_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        int cyc;
        int stalls;
        @(negedge clk);
        start = 1'b1; func_code = f; operand_a = a; operand_b = b;
        #1;
        check("stall_at_issue", {31'b0, stall}, 32'd1);
        check("no_done_at_issue", {31'b0, done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; operand_a = 16'h0; operand_b = 16'h0;
        cyc = 1;
        stalls = 0;
        while (!done && cyc < 40) begin
            if (stall) stalls++;
            @(negedge clk);
            cyc++;
        end
        check("done_cycle", cyc, 32'd17);
        check("stall_cycles", stalls, 32'd16);
        check("stall_in_done", {31'b0, stall}, 32'd0);
        check("busy_in_done", {31'b0, busy}, 32'd1);
    endtask

    task automatic watch_no_done(input int n, input string nm);
        int hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || div_by_zero) hits++;
        end
        check(nm, hits, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{F_MUL, 16'd300,  16'd200,  16'hEA60, 16'h0000};
        vecs[1]  = '{F_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE};
        vecs[2]  = '{F_MUL, 16'h1234, 16'h0001, 16'h1234, 16'h0000};
        vecs[3]  = '{F_MUL, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
        vecs[4]  = '{F_MUL, 16'h8000, 16'h0004, 16'h0000, 16'h0002};
        vecs[5]  = '{F_DIV, 16'd100,  16'd7,    16'd14,   16'd2};
        vecs[6]  = '{F_DIV, 16'h8000, 16'h0001, 16'h8000, 16'h0000};
        vecs[7]  = '{F_DIV, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[8]  = '{F_DIV, 16'd7,    16'd100,  16'd0,    16'd7};
        vecs[9]  = '{F_DIV, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F};
        vecs[10] = '{F_MUL, 16'hABCD, 16'h0100, 16'hCD00, 16'h00AB};

        rst_n = 1'b0; start = 1'b0; func_code = 4'h0;
        operand_a = 16'h0; operand_b = 16'h0; flush = 1'b0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        check("rst_lo", {16'b0, result_lo}, 32'd0);
        check("rst_hi", {16'b0, result_hi}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Each op issues on the cycle right after the previous done, so this
        // loop also exercises back-to-back acceptance.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_lo", i), {16'b0, result_lo}, {16'b0, vecs[i].lo});
            check($sformatf("vec%0d_hi", i), {16'b0, result_hi}, {16'b0, vecs[i].hi});
        end

        // Divide by zero: pulse once, no stall, results keep the last values.
        @(negedge clk);
        start = 1'b1; func_code = F_DIV; operand_a = 16'd5; operand_b = 16'd0;
        #1;
        check("dz_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("dz_pulse", {31'b0, div_by_zero}, 32'd1);
        check("dz_busy", {31'b0, busy}, 32'd0);
        watch_no_done(20, "dz_single_no_done");
        check("dz_keep_lo", {16'b0, result_lo}, 32'h0000CD00);
        check("dz_keep_hi", {16'b0, result_hi}, 32'h000000AB);

        // Flush a multiply at cycle 8.
        @(negedge clk);
        start = 1'b1; func_code = F_MUL; operand_a = 16'd3; operand_b = 16'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("flush_pre_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_stall", {31'b0, stall}, 32'd0);
        watch_no_done(20, "flush_no_done");
        check("flush_keep_lo", {16'b0, result_lo}, 32'h0000CD00);
        check("flush_keep_hi", {16'b0, result_hi}, 32'h000000AB);
        run_op(F_DIV, 16'd9, 16'd3);
        check("post_flush_q", {16'b0, result_lo}, 32'd3);
        check("post_flush_r", {16'b0, result_hi}, 32'd0);

        // Unsupported function code is ignored.
        @(negedge clk);
        start = 1'b1; func_code = F_ADD; operand_a = 16'd1; operand_b = 16'd2;
        #1;
        check("add_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("add_busy", {31'b0, busy}, 32'd0);
        watch_no_done(5, "add_no_done");

        // Async reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; func_code = F_DIV; operand_a = 16'h1234; operand_b = 16'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_stall", {31'b0, stall}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_lo", {16'b0, result_lo}, 32'd0);
        check("mid_rst_hi", {16'b0, result_hi}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done(25, "mid_rst_no_done");
        check("mid_rst_idle", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the ALU-class MUL and DIV function codes. These are the two instructions that write R0 as well as Rd.
- Sits beside the single-cycle ALU in the execute stage. It accepts an operation from the control/decode path and holds the pipeline in stall until the result is ready.
- Delivers a 2-word result: the low word goes to Rd, the high word goes to R0.
- Flags divide-by-zero so it can be ORed into alu_exception, which drives control's halt.

Parameters:
- DATA_WIDTH, 16, operand and result word width; iteration count = DATA_WIDTH.
- FUNCTION_CODE_WIDTH, 4, width of func_code.
- MUL, 4'b0001, multiply function code.
- DIV, 4'b0010, divide function code.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- func_code  input  FUNCTION_CODE_WIDTH  operation select, sampled with start
- operand_a  input  DATA_WIDTH  multiplicand / dividend
- operand_b  input  DATA_WIDTH  multiplier / divisor
- flush  input  1  synchronous abort of any operation in flight
- busy  output  1  high in MUL_RUN, DIV_RUN, DONE
- stall  output  1  pipeline hold request
- done  output  1  one-cycle pulse; result valid
- result_lo  output  DATA_WIDTH  product low word / quotient (to Rd)
- result_hi  output  DATA_WIDTH  product high word / remainder (to R0)
- div_by_zero  output  1  one-cycle pulse on DIV with operand_b == 0

Behaviour:
Reset
- Async on rst_n low: state=IDLE, counter=0, busy=0, done=0, div_by_zero=0, result_lo=0, result_hi=0, internal shift registers=0.
- Reset mid-operation abandons the operation. No done is produced.

States
- IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE, start && func_code==MUL → MUL_RUN. Latch operands; counter=DATA_WIDTH.
- IDLE, start && func_code==DIV && operand_b!=0 → DIV_RUN. Latch operands; counter=DATA_WIDTH.
- IDLE, start && func_code==DIV && operand_b==0 → remain IDLE. Pulse div_by_zero on the next cycle; results unchanged.
- IDLE, start with any other func_code → ignored, remain IDLE.
- MUL_RUN / DIV_RUN: one iteration per cycle, counter decrements. When counter reaches 1 and that iteration completes → DONE.
- DONE: done=1 for exactly one cycle; result registers load on entry. Unconditionally → IDLE.
- flush=1 in any state → IDLE next edge. No done, results unchanged. flush has priority over start and over iteration.

Arithmetic (unsigned only)
- MUL: shift-add. 2*DATA_WIDTH accumulator; {result_hi,result_lo} = a*b.
- DIV: restoring division, DATA_WIDTH+1-bit partial remainder. result_lo = a/b, result_hi = a%b.

Latency and stall
- start accepted at edge 0; done high during cycle DATA_WIDTH+1 (cycle 17 at default width).
- stall = (state==IDLE && start && (func_code==MUL || (func_code==DIV && operand_b!=0))) || state==MUL_RUN || state==DIV_RUN.
- stall is combinational so the issuing instruction holds from its first cycle.
- stall is low in DONE so the pipeline advances and captures the result that cycle.
- start while busy is ignored; operands are captured only at acceptance.
- result_lo/result_hi hold their last value until the next DONE.

Decomposition:
- Shared package (muldiv_pkg): MUL/DIV function code constants (the same values the control unit decodes) and the state enum {IDLE, MUL_RUN, DIV_RUN, DONE}.
- One sub-module: muldiv_iter_datapath. Holds the accumulator and shift registers and a per-cycle step for both modes, selected by a mode bit, with load/step controls.
- The FSM, counter, stall, done and div_by_zero logic stay in muldiv_sequencer.

Test Plan:
- MUL 300 × 200 → stall high cycles 0–16, done in cycle 17, result_hi=0x0000, result_lo=0xEA60; stall low in DONE.
- MUL 0xFFFF × 0xFFFF → result_hi=0xFFFE, result_lo=0x0001. A back-to-back start on the cycle after done is accepted and produces a correct second result.
- DIV 100 / 7 → result_lo=14, result_hi=2. DIV 0x8000 / 1 → result_lo=0x8000, result_hi=0.
- DIV 5 / 0 → div_by_zero pulses once, stall never asserts, no done, result registers keep their prior values.
- MUL started, flush at cycle 8 → IDLE next edge, no done, results unchanged. A new DIV 9 / 3 then yields 3 r 0.
- Start with func_code=ADD (4'b1111) → no stall, no busy. rst_n dropped mid-DIV → all outputs 0 immediately (async), no done afterward.
